// File: rtl/rv32i_trace_buffer.sv
// Commit-trace capture: retiring-instruction records go into a FIFO and are
// serialized as four 32-bit beats on a valid/ready stream. Never stalls the core.
module rv32i_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          commit,
    input  logic [31:0]   commit_pc,
    input  logic [31:0]   commit_ins,
    input  logic [4:0]    commit_rd,
    input  logic          commit_we,
    input  logic [31:0]   commit_wd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_last,
    output logic [AW:0]   level,
    output logic [15:0]   drop_cnt,
    output logic          overflow
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [15:0] seq;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } rec_t;

    typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} state_t;

    rec_t        mem [DEPTH];
    rec_t        head;
    state_t      state, state_nxt;
    logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [15:0] seq;
    logic        full, empty, push, pop, flush;

    assign flush = !rst_n || clear;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign pop   = (state == S_B3) && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push  = commit && (!full || pop);
    assign head  = mem[rd_ptr[AW-1:0]];

    assign wr_nxt = wr_ptr + (AW+1)'(push);
    assign rd_nxt = rd_ptr + (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (!flush && push)
            mem[wr_ptr[AW-1:0]] <= '{pc: commit_pc, ins: commit_ins, seq: seq,
                                     we: commit_we, rd: commit_rd, wd: commit_wd};
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            seq      <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            level  <= wr_nxt - rd_nxt;
            if (commit)
                seq <= seq + 16'd1;
            if (commit && !push) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (!empty)   state_nxt = S_B0;
            S_B0:   if (out_ready) state_nxt = S_B1;
            S_B1:   if (out_ready) state_nxt = S_B2;
            S_B2:   if (out_ready) state_nxt = S_B3;
            S_B3:   if (out_ready) state_nxt = (level > (AW+1)'(1)) ? S_B0 : S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Beats are muxed straight from the head entry, which stays put until popped.
    always_comb begin
        out_data = '0;
        case (state)
            S_B0:    out_data = head.pc;
            S_B1:    out_data = head.ins;
            S_B2:    out_data = {head.seq, 10'b0, head.we, head.rd};
            S_B3:    out_data = head.wd;
            default: out_data = '0;
        endcase
    end

    assign out_valid = (state != S_IDLE);
    assign out_last  = (state == S_B3);

endmodule

// File: tb/tb_rv32i_trace_buffer.sv
// Bench for rv32i_trace_buffer: queue-of-records model plus per-scenario tasks.
module tb_rv32i_trace_buffer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [32:0] SPUR = 33'h1_FFFF_FFFF;

    logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, commit = 1'b0, out_ready = 1'b0;
    logic [31:0] commit_pc = '0, commit_ins = '0, commit_wd = '0;
    logic [4:0]  commit_rd = '0;
    logic        commit_we = 1'b0;
    logic        out_valid, out_last, overflow;
    logic [31:0] out_data;
    logic [AW:0] level;
    logic [15:0] drop_cnt;

    rv32i_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .commit(commit),
        .commit_pc(commit_pc), .commit_ins(commit_ins), .commit_rd(commit_rd),
        .commit_we(commit_we), .commit_wd(commit_wd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .level(level), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, ins, wd;
        logic [4:0]  rd;
        logic        we;
        logic [15:0] seq;
    } mrec_t;

    mrec_t       m_q[$];
    int          bi;
    logic [15:0] m_seq, m_drop;
    logic        m_ovf;
    logic [32:0] obs[$], exp_q[$];
    bit          fixed;
    int          n_cmp = 0, n_bad = 0;

    logic        s_valid, s_last, s_ovf;
    logic [31:0] s_data;
    logic [AW:0] s_level;
    logic [15:0] s_drop;

    function automatic logic [31:0] beat(mrec_t r, int k);
        case (k)
            0:       return r.pc;
            1:       return r.ins;
            2:       return {r.seq, 10'b0, r.we, r.rd};
            default: return r.wd;
        endcase
    endfunction

    function automatic void model_reset();
        m_q.delete();
        bi = 0; m_seq = 0; m_drop = 0; m_ovf = 0;
    endfunction

    // One cycle: sample DUT at negedge, drive next inputs, advance the model.
    task automatic step(input bit c, input bit r, input bit clr);
        bit    hs, popping;
        mrec_t nr;
        @(negedge clk);
        s_valid = out_valid; s_data = out_data; s_last = out_last;
        s_level = level; s_drop = drop_cnt; s_ovf = overflow;
        commit = c; out_ready = r; clear = clr;
        if (c && !fixed) begin
            commit_pc = $urandom; commit_ins = $urandom; commit_wd = $urandom;
            commit_rd = 5'($urandom); commit_we = 1'($urandom);
        end
        hs = out_valid && r;
        popping = 0;
        if (clr) begin
            model_reset();
        end else begin
            if (hs) begin
                obs.push_back({out_last, out_data});
                if (m_q.size() == 0) exp_q.push_back(SPUR);
                else begin
                    exp_q.push_back({bi == 3, beat(m_q[0], bi)});
                    if (bi == 3) begin popping = 1; bi = 0; end
                    else bi++;
                end
            end
            if (c) begin
                nr = '{pc: commit_pc, ins: commit_ins, wd: commit_wd, rd: commit_rd,
                       we: commit_we, seq: m_seq};
                if (m_q.size() < DEPTH || popping) begin
                    if (popping) void'(m_q.pop_front());
                    popping = 0;
                    m_q.push_back(nr);
                end else begin
                    m_ovf = 1;
                    if (m_drop != 16'hFFFF) m_drop++;
                end
                m_seq++;
            end
            if (popping) void'(m_q.pop_front());
        end
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            step(0, 1, 0);
            if (m_q.size() == 0 && !s_valid) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            commit = 1; commit_pc = $urandom; clear = 0; out_ready = 1;
        end
        @(negedge clk);
        commit = 0; rst_n = 1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", out_last); end
        n_cmp++; if (level !== '0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
        n_cmp++; if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
    endtask

    task automatic test_single();
        bit ok;
        logic [32:0] want [4];
        want[0] = {1'b0, 32'h0000_0000}; want[1] = {1'b0, 32'h0050_0093};
        want[2] = {1'b0, 32'h0000_0021}; want[3] = {1'b1, 32'h0000_0005};
        obs.delete(); exp_q.delete();
        fixed = 1;
        commit_pc = 32'h0; commit_ins = 32'h0050_0093; commit_rd = 5'd1; commit_we = 1; commit_wd = 32'd5;
        step(1, 1, 0);
        step(0, 1, 0);
        n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL single_latency_n1 got %b want 0", s_valid); end
        n_cmp++; if (s_level !== 5'd1) begin n_bad++; $display("FAIL single_level1 got %0d want 1", s_level); end
        step(0, 1, 0);
        n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency_n2 got %b want 1", s_valid); end
        fixed = 0;
        drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_drain got timeout want done"); end
        n_cmp++; if (s_level !== 5'd0) begin n_bad++; $display("FAIL single_level0 got %0d want 0", s_level); end
        n_cmp++; if (obs.size() != 4) begin n_bad++; $display("FAIL single_beats got %0d want 4", obs.size()); end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== want[i] || obs[i] !== exp_q[i])
                begin n_bad++; $display("FAIL single_beat%0d got %h want %h", i, obs[i], want[i]); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        obs.delete(); exp_q.delete();
        step(0, 0, 1);
        fixed = 1;
        commit_pc = 32'h100; commit_ins = 32'h0050_0093; commit_rd = 5'd1; commit_we = 1; commit_wd = 32'd5;
        step(1, 1, 0);
        fixed = 0;
        for (int i = 0; i < 20 && bi != 2; i++) step(0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            n_cmp++;
            if (s_valid !== 1'b1 || s_data !== 32'h0000_0021 || s_last !== 1'b0)
                begin n_bad++; $display("FAIL stall_hold%0d got v=%b d=%h l=%b want v=1 d=00000021 l=0", i, s_valid, s_data, s_last); end
        end
        drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_drain got timeout want done"); end
        n_cmp++; if (obs.size() != 4) begin n_bad++; $display("FAIL stall_beats got %0d want 4", obs.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_beat%0d got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int nrec;
        obs.delete(); exp_q.delete();
        step(0, 0, 1);
        for (int i = 0; i < DEPTH + 3; i++) step(1, 0, 0);
        step(0, 0, 0);
        n_cmp++; if (s_level !== 5'd16) begin n_bad++; $display("FAIL ovf_level got %0d want 16", s_level); end
        n_cmp++; if (s_drop !== 16'd3) begin n_bad++; $display("FAIL ovf_drop got %0d want 3", s_drop); end
        n_cmp++; if (s_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", s_ovf); end
        drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_drain got timeout want done"); end
        nrec = obs.size() / 4;
        n_cmp++; if (obs.size() != 4 * DEPTH) begin n_bad++; $display("FAIL ovf_beats got %0d want %0d", obs.size(), 4 * DEPTH); end
        for (int i = 0; i < nrec; i++) begin
            n_cmp++;
            if (obs[4*i+2][31:16] !== 16'(i)) begin n_bad++; $display("FAIL ovf_seq%0d got %0d want %0d", i, obs[4*i+2][31:16], i); end
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_beat%0d got %h want %h", i, obs[i], exp_q[i]); end
        end
        obs.delete(); exp_q.delete();
        step(1, 1, 0);
        drain(ok);
        n_cmp++;
        if (!ok || obs.size() != 4) begin n_bad++; $display("FAIL ovf_next_rec got %0d beats want 4", obs.size()); end
        else if (obs[2][31:16] !== 16'd19) begin n_bad++; $display("FAIL ovf_next_seq got %0d want 19", obs[2][31:16]); end
    endtask

    task automatic test_clear();
        bit ok;
        obs.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        for (int i = 0; i < 20 && bi != 1; i++) step(0, 1, 0);
        step(1, 0, 1);
        n_cmp++; if (s_valid !== 1'b1 || s_drop !== 16'd3) begin n_bad++; $display("FAIL clr_pre got v=%b drop=%0d want v=1 drop=3", s_valid, s_drop); end
        step(0, 0, 0);
        n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid got %b want 0", s_valid); end
        n_cmp++; if (s_level !== 5'd0) begin n_bad++; $display("FAIL clr_level got %0d want 0", s_level); end
        n_cmp++; if (s_drop !== 16'd0) begin n_bad++; $display("FAIL clr_drop got %0d want 0", s_drop); end
        n_cmp++; if (s_ovf !== 1'b0) begin n_bad++; $display("FAIL clr_ovf got %b want 0", s_ovf); end
        obs.delete(); exp_q.delete();
        step(1, 1, 0);
        drain(ok);
        n_cmp++;
        if (!ok || obs.size() != 4) begin n_bad++; $display("FAIL clr_next_rec got %0d beats want 4", obs.size()); end
        else if (obs[2][31:16] !== 16'd0 || obs[3] !== exp_q[3]) begin n_bad++; $display("FAIL clr_next_seq got %0d want 0", obs[2][31:16]); end
    endtask

    task automatic test_full_push_pop();
        bit ok;
        obs.delete(); exp_q.delete();
        step(0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
        for (int i = 0; i < 20 && bi != 3; i++) step(0, 1, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        n_cmp++; if (s_level !== 5'd16) begin n_bad++; $display("FAIL fpp_level got %0d want 16", s_level); end
        n_cmp++; if (s_drop !== 16'd0 || s_ovf !== 1'b0) begin n_bad++; $display("FAIL fpp_drop got %0d/%b want 0/0", s_drop, s_ovf); end
        drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fpp_drain got timeout want done"); end
        n_cmp++; if (obs.size() != 4 * (DEPTH + 1)) begin n_bad++; $display("FAIL fpp_beats got %0d want %0d", obs.size(), 4 * (DEPTH + 1)); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL fpp_beat%0d got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_wrap();
        bit ok;
        obs.delete(); exp_q.delete();
        step(0, 0, 1);
        for (int i = 0; i < 3000 && m_seq < 16'd40; i++)
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), 0);
        n_cmp++; if (m_seq !== 16'd40) begin n_bad++; $display("FAIL rnd_commits got %0d want 40", m_seq); end
        drain(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_drain got timeout want done"); end
        n_cmp++; if (s_drop !== m_drop || s_drop !== 16'd0) begin n_bad++; $display("FAIL rnd_drop got %0d want 0", s_drop); end
        n_cmp++; if (obs.size() != 160) begin n_bad++; $display("FAIL rnd_beats got %0d want 160", obs.size()); end
        for (int i = 0; i < obs.size() / 4; i++) begin
            n_cmp++;
            if (obs[4*i+2][31:16] !== 16'(i)) begin n_bad++; $display("FAIL rnd_seq%0d got %0d want %0d", i, obs[4*i+2][31:16], i); end
        end
        foreach (exp_q[i]) if (i < obs.size()) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd_beat%0d got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    initial begin
        fixed = 0;
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_clear();
        test_full_push_pop();
        test_random_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
